// File: rtl/rms_window_sqrt_if.sv
// Signal bundle between the RMS windowing/root stage and its producer/readout logic.
// The stage itself connects through the slave modport.
interface rms_window_sqrt_if;
    logic        clear;
    logic        sq_valid;
    logic [30:0] sq_in;
    logic [30:0] ms_out;
    logic [15:0] rms_out;
    logic        rms_valid;
    logic        busy;
    logic        overrun;

    modport slave (
        input  clear, sq_valid, sq_in,
        output ms_out, rms_out, rms_valid, busy, overrun
    );

    modport master (
        output clear, sq_valid, sq_in,
        input  ms_out, rms_out, rms_valid, busy, overrun
    );
endinterface

// File: rtl/rms_window_sqrt.sv
// Windowed mean of squared samples followed by a 16-step restoring square root.
// Accumulation keeps running while the root engine is busy; windows that finish mid-root are dropped.
module rms_window_sqrt #(
    parameter int LOG2_N = 5
) (
    input  logic              clk,
    input  logic              rstn,
    rms_window_sqrt_if.slave  bus
);
    localparam int ACC_W = 31 + LOG2_N;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CALC = 1'b1;
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [LOG2_N-1:0] cnt_q, cnt_d;
    logic [0:0]        state_q, state_d;
    logic [30:0]       ms_q, ms_d;
    logic [15:0]       rms_q, rms_d;
    logic              rv_q, rv_d;
    logic              ovr_q, ovr_d;
    logic [31:0]       rad_q, rad_d;
    logic [17:0]       rem_q, rem_d;
    logic [15:0]       root_q, root_d;
    logic [3:0]        iter_q, iter_d;

    logic [ACC_W-1:0]  sum;
    logic [30:0]       mean;
    logic [19:0]       rem_sh;
    logic [19:0]       trial;
    logic              ge;
    logic [15:0]       root_it;

    assign sum     = acc_q + ACC_W'(bus.sq_in);
    assign mean    = sum[ACC_W-1:LOG2_N];

    // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
    assign rem_sh  = {rem_q, rad_q[31:30]};
    assign trial   = {2'b00, root_q, 2'b01};
    assign ge      = (rem_sh >= trial);
    assign root_it = {root_q[14:0], ge};

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        ms_d    = ms_q;
        rms_d   = rms_q;
        rv_d    = 1'b0;
        ovr_d   = ovr_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        iter_d  = iter_q;

        if (bus.clear) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
            ovr_d   = 1'b0;
        end else begin
            if (state_q == CALC) begin
                rad_d  = {rad_q[29:0], 2'b00};
                rem_d  = ge ? 18'(rem_sh - trial) : rem_sh[17:0];
                root_d = root_it;
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    rms_d   = root_it;
                    rv_d    = 1'b1;
                    state_d = IDLE;
                end
            end

            if (bus.sq_valid) begin
                if (cnt_q == CNT_LAST) begin
                    acc_d = '0;
                    cnt_d = '0;
                    // CALC-state check uses the pre-edge state, so the final root edge still counts as busy.
                    if (state_q == IDLE) begin
                        ms_d    = mean;
                        rad_d   = {1'b0, mean};
                        rem_d   = '0;
                        root_d  = '0;
                        iter_d  = '0;
                        state_d = CALC;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            ms_q    <= '0;
            rms_q   <= '0;
            rv_q    <= 1'b0;
            ovr_q   <= 1'b0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            iter_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            ms_q    <= ms_d;
            rms_q   <= rms_d;
            rv_q    <= rv_d;
            ovr_q   <= ovr_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            iter_q  <= iter_d;
        end
    end

    assign bus.ms_out    = ms_q;
    assign bus.rms_out   = rms_q;
    assign bus.rms_valid = rv_q;
    assign bus.busy      = (state_q == CALC);
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_rms_window_sqrt.sv
// Directed bench: a 32-sample-window instance for the main function and a 4-sample-window
// instance for overrun behaviour, sharing clock and reset.
module tb_rms_window_sqrt;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rms_window_sqrt_if if5 ();
    rms_window_sqrt_if if2 ();

    rms_window_sqrt #(.LOG2_N(5)) u5 (.clk(clk), .rstn(rstn), .bus(if5));
    rms_window_sqrt #(.LOG2_N(2)) u2 (.clk(clk), .rstn(rstn), .bus(if2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint isqrt(input longint x);
        longint r = 0;
        for (longint b = 32768; b > 0; b = b >> 1)
            if ((r + b) * (r + b) <= x) r = r + b;
        return r;
    endfunction

    // Feed a full window of one value to the N=32 instance; returns right after E0.
    task automatic win5(input logic [30:0] v);
        for (int i = 0; i < 32; i++) begin
            if5.sq_valid = 1'b1;
            if5.sq_in    = v;
            tick();
        end
        if5.sq_valid = 1'b0;
    endtask

    // Called right after E0: checks ms_out, then the 16-cycle root latency and 1-cycle pulse.
    task automatic expect5(input string tag, input logic [30:0] ms, input logic [15:0] rms);
        logic early = 1'b0;
        $display("window %s: expect ms_out=%0d rms_out=%0d", tag, ms, rms);
        chk({tag, "_ms"}, if5.ms_out, ms);
        chk({tag, "_busy_E0"}, if5.busy, 1);
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (if5.rms_valid || !if5.busy) early = 1'b1;
        end
        chk({tag, "_no_early"}, early, 0);
        tick();
        chk({tag, "_valid_E16"}, if5.rms_valid, 1);
        chk({tag, "_rms"}, if5.rms_out, rms);
        chk({tag, "_busy_E16"}, if5.busy, 0);
        tick();
        chk({tag, "_valid_E17"}, if5.rms_valid, 0);
    endtask

    initial begin
        longint sum;
        logic [30:0] v;
        int acc;
        logic seen;

        if5.clear = 0; if5.sq_valid = 0; if5.sq_in = '0;
        if2.clear = 0; if2.sq_valid = 0; if2.sq_in = '0;
        tick(); tick();
        chk("rst_ms", if5.ms_out, 0);
        chk("rst_rms", if5.rms_out, 0);
        chk("rst_valid", if5.rms_valid, 0);
        chk("rst_busy", if5.busy, 0);
        chk("rst_ovr", if5.overrun, 0);
        rstn = 1'b1;
        tick();

        win5(31'd10000);      expect5("const", 31'd10000, 16'd100);
        win5(31'd1073741824); expect5("full", 31'd1073741824, 16'd32768);
        win5(31'd0);          expect5("zero", 31'd0, 16'd0);

        for (int i = 0; i < 32; i++) begin
            if5.sq_valid = 1'b1;
            if5.sq_in    = (i < 31) ? 31'd1 : 31'd0;
            tick();
        end
        if5.sq_valid = 1'b0;
        expect5("trunc", 31'd0, 16'd0);

        win5(31'd99); expect5("floor99", 31'd99, 16'd9);

        sum = 0;
        for (int i = 0; i < 32; i++) begin
            v = 31'($urandom_range(0, 32'h4000_0000));
            sum += longint'(v);
            if5.sq_valid = 1'b1;
            if5.sq_in    = v;
            tick();
        end
        if5.sq_valid = 1'b0;
        expect5("random", 31'(sum >> 5), 16'(isqrt(sum >> 5)));

        acc = 0;
        for (int i = 0; i < 2000 && acc < 32; i++) begin
            if5.sq_valid = 1'($urandom_range(0, 1));
            if5.sq_in    = 31'd400;
            tick();
            if (if5.sq_valid) acc++;
        end
        if5.sq_valid = 1'b0;
        chk("gap_count", acc, 32);
        expect5("gapped", 31'd400, 16'd20);

        // Overrun on the 4-sample instance: first window 16, second (dropped) window 100.
        for (int i = 1; i <= 20; i++) begin
            if2.sq_valid = 1'b1;
            if2.sq_in    = (i >= 5 && i <= 8) ? 31'd100 : 31'd16;
            tick();
            if (i == 4) chk("ovr_busy_E0", if2.busy, 1);
            if (i == 7) chk("ovr_not_yet", if2.overrun, 0);
            if (i == 8) begin
                chk("ovr_set", if2.overrun, 1);
                chk("ovr_ms_held", if2.ms_out, 16);
            end
        end
        if2.sq_valid = 1'b0;
        $display("overrun: E16 reached, expect rms_out=4");
        chk("ovr_valid", if2.rms_valid, 1);
        chk("ovr_rms", if2.rms_out, 4);
        chk("ovr_ms_final", if2.ms_out, 16);
        if2.clear = 1'b1;
        tick();
        if2.clear = 1'b0;
        chk("clr_ovr", if2.overrun, 0);
        chk("clr_busy", if2.busy, 0);
        chk("clr_ms_hold", if2.ms_out, 16);

        // Asynchronous reset at E8 of a root calculation.
        win5(31'd10000);
        chk("rstcalc_busy", if5.busy, 1);
        for (int k = 0; k < 8; k++) tick();
        #2 rstn = 1'b0;
        #1;
        $display("reset asserted mid-CALC");
        chk("arst_ms", if5.ms_out, 0);
        chk("arst_rms", if5.rms_out, 0);
        chk("arst_busy", if5.busy, 0);
        tick(); tick();
        rstn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (if5.rms_valid) seen = 1'b1;
        end
        chk("arst_no_valid", seen, 0);

        // clear together with a valid sample after 10 samples restarts the window.
        for (int i = 0; i < 10; i++) begin
            if5.sq_valid = 1'b1;
            if5.sq_in    = 31'd50000;
            tick();
        end
        if5.clear = 1'b1;
        tick();
        if5.clear = 1'b0;
        if5.sq_valid = 1'b0;
        chk("clr_busy5", if5.busy, 0);
        win5(31'd2500); expect5("after_clear", 31'd2500, 16'd50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
